// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared bus constants, tag width and requester types for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int MEM_TAG_W = 4;
    localparam int NUM_TAGS = 1 << MEM_TAG_W;
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;
    typedef enum logic {REQ_IMEM, REQ_DMEM} requester_t;
    typedef enum logic {PRIO_IMEM, PRIO_DMEM} prio_t;
endpackage

// File: rtl/mem_port_arbiter_tag_owner.sv
// mem_tag_owner_table: remembers which requester issued each in-flight load tag,
// routes returned tags to that owner, keeps per-requester in-flight counts and flags protocol errors
module mem_tag_owner_table
    import mem_port_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 assign_i,
    input  logic [MEM_TAG_W-1:0] assign_tag_i,
    input  requester_t           assign_owner_i,
    input  logic [MEM_TAG_W-1:0] ret_tag_i,
    output logic [MEM_TAG_W-1:0] imem_tag_o,
    output logic [MEM_TAG_W-1:0] dmem_tag_o,
    output logic [3:0]           imem_outst_o,
    output logic [3:0]           dmem_outst_o,
    output logic                 err_o
);
    logic [NUM_TAGS-1:0] valid_q, valid_d, owner_dmem_q, owner_dmem_d;
    logic [3:0] imem_cnt_q, imem_cnt_d, dmem_cnt_q, dmem_cnt_d;
    logic err_q, err_d, ret_hit, ret_dmem, reuse;

    // A return and a new assignment of the same tag: the return uses the old owner, the write wins.
    always_comb begin
        ret_hit = ret_tag_i != '0 && valid_q[ret_tag_i];
        ret_dmem = owner_dmem_q[ret_tag_i];
        reuse = assign_i && valid_q[assign_tag_i] && assign_tag_i != ret_tag_i;
        valid_d = valid_q;
        owner_dmem_d = owner_dmem_q;
        if (ret_hit) valid_d[ret_tag_i] = 1'b0;
        if (assign_i) begin
            valid_d[assign_tag_i] = 1'b1;
            owner_dmem_d[assign_tag_i] = assign_owner_i == REQ_DMEM;
        end
        imem_cnt_d = imem_cnt_q + 4'(assign_i && assign_owner_i == REQ_IMEM) - 4'(ret_hit && !ret_dmem);
        dmem_cnt_d = dmem_cnt_q + 4'(assign_i && assign_owner_i == REQ_DMEM) - 4'(ret_hit && ret_dmem);
        err_d = err_q || (ret_tag_i != '0 && !valid_q[ret_tag_i]) || reuse;
        imem_tag_o = ret_hit && !ret_dmem ? ret_tag_i : '0;
        dmem_tag_o = ret_hit && ret_dmem ? ret_tag_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            owner_dmem_q <= '0;
            imem_cnt_q <= '0;
            dmem_cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            owner_dmem_q <= owner_dmem_d;
            imem_cnt_q <= imem_cnt_d;
            dmem_cnt_q <= dmem_cnt_d;
            err_q <= err_d;
        end
    end

    assign imem_outst_o = imem_cnt_q;
    assign dmem_outst_o = dmem_cnt_q;
    assign err_o = err_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the off-chip memory port between Imem and Dmem with burst-limited
// priority, per-requester in-flight load limits and tag-based return routing
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST      = 4,
    parameter int IMEM_MAX_OUTST = 4,
    parameter int DMEM_MAX_OUTST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           imem_cmd_i,
    input  logic [63:0]          imem_addr_i,
    output logic [MEM_TAG_W-1:0] imem_response_o,
    output logic [MEM_TAG_W-1:0] imem_tag_o,
    output logic [63:0]          imem_data_o,
    input  logic [1:0]           dmem_cmd_i,
    input  logic [63:0]          dmem_addr_i,
    input  logic [63:0]          dmem_data_i,
    output logic [MEM_TAG_W-1:0] dmem_response_o,
    output logic [MEM_TAG_W-1:0] dmem_tag_o,
    output logic [63:0]          dmem_data_o,
    output logic [1:0]           proc2mem_command_o,
    output logic [63:0]          proc2mem_addr_o,
    output logic [63:0]          proc2mem_data_o,
    input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
    input  logic [63:0]          mem2proc_data_i,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
    output logic [3:0]           imem_outst_o,
    output logic [3:0]           dmem_outst_o,
    output logic                 err_o
);
    localparam logic [3:0] IMEM_LIM = 4'(IMEM_MAX_OUTST);
    localparam logic [3:0] DMEM_LIM = 4'(DMEM_MAX_OUTST);
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    prio_t prio_q;
    logic [BW-1:0] burst_q;
    logic imem_elig, dmem_elig, any_elig, other_elig, accept, load_accept;
    requester_t winner, holder;
    logic [MEM_TAG_W-1:0] ret_tag;

    // Reset masks both requesters so the port stays idle and no tag state is touched.
    always_comb begin
        imem_elig = !rst && imem_cmd_i != BUS_NONE && imem_outst_o < IMEM_LIM;
        dmem_elig = !rst && dmem_cmd_i != BUS_NONE && (dmem_cmd_i == BUS_STORE || dmem_outst_o < DMEM_LIM);
        any_elig = imem_elig || dmem_elig;
        holder = prio_q == PRIO_DMEM ? REQ_DMEM : REQ_IMEM;
        winner = imem_elig && dmem_elig ? holder : (imem_elig ? REQ_IMEM : REQ_DMEM);
        other_elig = winner == REQ_IMEM ? dmem_elig : imem_elig;
        proc2mem_command_o = !any_elig ? BUS_NONE : (winner == REQ_IMEM ? imem_cmd_i : dmem_cmd_i);
        proc2mem_addr_o = !any_elig ? '0 : (winner == REQ_IMEM ? imem_addr_i : dmem_addr_i);
        proc2mem_data_o = rst ? '0 : dmem_data_i;
        imem_response_o = any_elig && winner == REQ_IMEM ? mem2proc_response_i : '0;
        dmem_response_o = any_elig && winner == REQ_DMEM ? mem2proc_response_i : '0;
        accept = any_elig && mem2proc_response_i != '0;
        load_accept = accept && proc2mem_command_o == BUS_LOAD;
        ret_tag = rst ? '0 : mem2proc_tag_i;
        imem_data_o = mem2proc_data_i;
        dmem_data_o = mem2proc_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_IMEM;
            burst_q <= '0;
        end else if (accept && winner != holder) begin
            prio_q <= winner == REQ_DMEM ? PRIO_DMEM : PRIO_IMEM;
            burst_q <= '0;
        end else if (accept && other_elig && burst_q == BURST_LAST) begin
            prio_q <= prio_q == PRIO_IMEM ? PRIO_DMEM : PRIO_IMEM;
            burst_q <= '0;
        end else if (accept && other_elig) begin
            burst_q <= burst_q + BW'(1);
        end
    end

    mem_tag_owner_table u_owner (
        .clk           (clk),
        .rst           (rst),
        .assign_i      (load_accept),
        .assign_tag_i  (mem2proc_response_i),
        .assign_owner_i(winner),
        .ret_tag_i     (ret_tag),
        .imem_tag_o    (imem_tag_o),
        .dmem_tag_o    (dmem_tag_o),
        .imem_outst_o  (imem_outst_o),
        .dmem_outst_o  (dmem_outst_o),
        .err_o         (err_o)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a tag/count/priority model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int MAXB = 4, ILIM = 4, DLIM = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] imem_cmd = '0, dmem_cmd = '0;
    logic [63:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_data = '0;
    logic [3:0] mem_resp = '0, mem_tag = '0;
    logic [3:0] imem_response, imem_tag, dmem_response, dmem_tag, imem_outst, dmem_outst;
    logic [63:0] imem_data, dmem_data, p_addr, p_data;
    logic [1:0] p_cmd;
    logic err;

    mem_port_arbiter #(.MAX_BURST(MAXB), .IMEM_MAX_OUTST(ILIM), .DMEM_MAX_OUTST(DLIM)) dut (
        .clk(clk), .rst(rst),
        .imem_cmd_i(imem_cmd), .imem_addr_i(imem_addr),
        .imem_response_o(imem_response), .imem_tag_o(imem_tag), .imem_data_o(imem_data),
        .dmem_cmd_i(dmem_cmd), .dmem_addr_i(dmem_addr), .dmem_data_i(dmem_wdata),
        .dmem_response_o(dmem_response), .dmem_tag_o(dmem_tag), .dmem_data_o(dmem_data),
        .proc2mem_command_o(p_cmd), .proc2mem_addr_o(p_addr), .proc2mem_data_o(p_data),
        .mem2proc_response_i(mem_resp), .mem2proc_data_i(mem_data), .mem2proc_tag_i(mem_tag),
        .imem_outst_o(imem_outst), .dmem_outst_o(dmem_outst), .err_o(err)
    );

    int checks = 0, errors = 0;

    // Reference model: owner per tag (0 none, 1 Imem, 2 Dmem), counts, priority side and run length.
    int m_owner[16];
    int m_icnt, m_dcnt, m_prio, m_burst;
    bit m_err;

    function automatic bit i_elig();
        return imem_cmd != BUS_NONE && m_icnt < ILIM;
    endfunction

    function automatic bit d_elig();
        return dmem_cmd != BUS_NONE && (dmem_cmd == BUS_STORE || m_dcnt < DLIM);
    endfunction

    function automatic int model_win();
        if (i_elig() && d_elig()) return m_prio;
        if (i_elig()) return 0;
        if (d_elig()) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_owner[i] = 0;
        m_icnt = 0; m_dcnt = 0; m_prio = 0; m_burst = 0; m_err = 0;
    endtask

    task automatic model_commit();
        int w;
        bit ie, de, acc, was_valid;
        w = model_win();
        ie = i_elig();
        de = d_elig();
        acc = w >= 0 && mem_resp != 0;
        was_valid = m_owner[mem_resp] != 0;
        if (mem_tag != 0) begin
            if (m_owner[mem_tag] == 1) m_icnt--;
            else if (m_owner[mem_tag] == 2) m_dcnt--;
            else m_err = 1;
            m_owner[mem_tag] = 0;
        end
        if (acc && (w == 0 ? imem_cmd : dmem_cmd) == BUS_LOAD) begin
            if (was_valid && mem_resp != mem_tag) m_err = 1;
            m_owner[mem_resp] = w + 1;
            if (w == 0) m_icnt++; else m_dcnt++;
        end
        if (acc) begin
            if (w != m_prio) begin
                m_prio = w; m_burst = 0;
            end else if (w == 0 ? de : ie) begin
                m_burst++;
                if (m_burst == MAXB) begin m_prio = 1 - m_prio; m_burst = 0; end
            end
        end
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] ic, input logic [1:0] dc, input logic [3:0] resp, input logic [3:0] tag);
        imem_cmd = ic; dmem_cmd = dc; mem_resp = resp; mem_tag = tag;
        imem_addr = {$urandom, $urandom};
        dmem_addr = {$urandom, $urandom};
        dmem_wdata = {$urandom, $urandom};
        mem_data = {$urandom, $urandom};
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(BUS_NONE, BUS_NONE, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(BUS_LOAD, BUS_LOAD, 3, 9);
        checks++; if (p_cmd !== BUS_NONE) begin errors++; $display("FAIL reset_cmd: got %0h expected %0h", p_cmd, BUS_NONE); end
        checks++; if (p_addr !== 64'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", p_addr); end
        checks++; if (imem_response !== 4'd0 || dmem_response !== 4'd0) begin errors++; $display("FAIL reset_resp: got %0h/%0h expected 0/0", imem_response, dmem_response); end
        checks++; if (imem_tag !== 4'd0 || dmem_tag !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0h/%0h expected 0/0", imem_tag, dmem_tag); end
        @(negedge clk);
        drive(BUS_NONE, BUS_NONE, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (imem_outst !== 4'd0 || dmem_outst !== 4'd0) begin errors++; $display("FAIL reset_outst: got %0h/%0h expected 0/0", imem_outst, dmem_outst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    endtask

    task automatic test_imem_loads();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(BUS_LOAD, BUS_NONE, 4'(i), 0);
            checks++; if (imem_response !== 4'(i)) begin errors++; $display("FAIL imem_resp%0d: got %0h expected %0h", i, imem_response, i); end
            checks++; if (p_cmd !== BUS_LOAD || p_addr !== imem_addr) begin errors++; $display("FAIL imem_port%0d: got %0h/%0h expected %0h/%0h", i, p_cmd, p_addr, BUS_LOAD, imem_addr); end
            tick();
        end
        drive(BUS_NONE, BUS_NONE, 0, 2);
        checks++; if (imem_tag !== 4'd2 || dmem_tag !== 4'd0) begin errors++; $display("FAIL imem_return_tag: got %0h/%0h expected 2/0", imem_tag, dmem_tag); end
        checks++; if (imem_data !== mem_data) begin errors++; $display("FAIL imem_return_data: got %0h expected %0h", imem_data, mem_data); end
        checks++; if (imem_outst !== 4'd3) begin errors++; $display("FAIL imem_outst_pre: got %0d expected 3", imem_outst); end
        tick();
        drive(BUS_NONE, BUS_NONE, 0, 0);
        checks++; if (imem_outst !== 4'd2) begin errors++; $display("FAIL imem_outst_post: got %0d expected 2", imem_outst); end
    endtask

    task automatic test_burst();
        string pat = "IIIIDDDDIIII";
        byte got;
        logic [3:0] last = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(BUS_LOAD, BUS_LOAD, 4'(i + 1), last);
            got = imem_response != 0 ? "I" : (dmem_response != 0 ? "D" : "-");
            checks++; if (got !== pat[i]) begin errors++; $display("FAIL burst_grant%0d: got %c expected %c", i, got, pat[i]); end
            last = 4'(i + 1);
            tick();
        end
        drive(BUS_NONE, BUS_NONE, 0, last);
        tick();
        drive(BUS_NONE, BUS_NONE, 0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL burst_err: got %0b expected 0", err); end
    endtask

    task automatic test_reject();
        string pat = "IIIID";
        byte got;
        logic [3:0] last = 0, tag = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && i < 7) begin
                drive(BUS_LOAD, BUS_LOAD, 0, last);
                last = 0;
                checks++; if (imem_response !== 4'd0 || dmem_response !== 4'd0) begin errors++; $display("FAIL reject_resp%0d: got %0h/%0h expected 0/0", i, imem_response, dmem_response); end
                checks++; if (p_addr !== imem_addr) begin errors++; $display("FAIL reject_owner%0d: got %0h expected %0h", i, p_addr, imem_addr); end
            end else begin
                drive(BUS_LOAD, BUS_LOAD, tag, last);
                got = imem_response != 0 ? "I" : (dmem_response != 0 ? "D" : "-");
                checks++; if (got !== pat[i < 2 ? i : i - 5]) begin errors++; $display("FAIL reject_grant%0d: got %c expected %c", i, got, pat[i < 2 ? i : i - 5]); end
                last = tag;
                tag++;
            end
            tick();
        end
        drive(BUS_NONE, BUS_NONE, 0, last);
        tick();
    endtask

    task automatic test_limit();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(BUS_LOAD, BUS_NONE, 4'(i), 0);
            tick();
        end
        drive(BUS_LOAD, BUS_LOAD, 5, 0);
        checks++; if (imem_outst !== 4'd4) begin errors++; $display("FAIL limit_outst: got %0d expected 4", imem_outst); end
        checks++; if (dmem_response !== 4'd5 || imem_response !== 4'd0) begin errors++; $display("FAIL limit_grant: got %0h/%0h expected 0/5", imem_response, dmem_response); end
        tick();
        drive(BUS_LOAD, BUS_NONE, 6, 1);
        checks++; if (imem_response !== 4'd0 || p_cmd !== BUS_NONE) begin errors++; $display("FAIL limit_masked: got %0h/%0h expected 0/0", imem_response, p_cmd); end
        tick();
        drive(BUS_LOAD, BUS_NONE, 6, 0);
        checks++; if (imem_response !== 4'd6) begin errors++; $display("FAIL limit_retry: got %0h expected 6", imem_response); end
        tick();
        for (int t = 2; t <= 6; t++) begin
            drive(BUS_NONE, BUS_NONE, 0, 4'(t));
            tick();
        end
        drive(BUS_NONE, BUS_NONE, 0, 0);
        checks++; if (imem_outst !== 4'd0 || dmem_outst !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL limit_drain: got %0d/%0d/%0b expected 0/0/0", imem_outst, dmem_outst, err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(BUS_LOAD, BUS_NONE, 5, 0);
        tick();
        drive(BUS_NONE, BUS_LOAD, 5, 5);
        checks++; if (imem_tag !== 4'd5 || dmem_tag !== 4'd0) begin errors++; $display("FAIL same_old_owner: got %0h/%0h expected 5/0", imem_tag, dmem_tag); end
        checks++; if (dmem_response !== 4'd5) begin errors++; $display("FAIL same_assign: got %0h expected 5", dmem_response); end
        tick();
        drive(BUS_NONE, BUS_NONE, 0, 5);
        checks++; if (dmem_tag !== 4'd5 || imem_tag !== 4'd0) begin errors++; $display("FAIL same_new_owner: got %0h/%0h expected 0/5", imem_tag, dmem_tag); end
        checks++; if (dmem_data !== mem_data) begin errors++; $display("FAIL same_data: got %0h expected %0h", dmem_data, mem_data); end
        tick();
        drive(BUS_NONE, BUS_NONE, 0, 0);
        checks++; if (err !== 1'b0 || imem_outst !== 4'd0 || dmem_outst !== 4'd0) begin errors++; $display("FAIL same_final: got %0b/%0d/%0d expected 0/0/0", err, imem_outst, dmem_outst); end
    endtask

    task automatic test_unknown_tag();
        do_reset();
        drive(BUS_NONE, BUS_NONE, 0, 9);
        checks++; if (imem_tag !== 4'd0 || dmem_tag !== 4'd0) begin errors++; $display("FAIL unknown_tags: got %0h/%0h expected 0/0", imem_tag, dmem_tag); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(BUS_NONE, BUS_NONE, 0, 0);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL unknown_sticky%0d: got %0b expected 1", i, err); end
            tick();
        end
        do_reset();
        drive(BUS_NONE, BUS_NONE, 0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL unknown_cleared: got %0b expected 0", err); end
    endtask

    task automatic test_random();
        int w, t;
        logic [1:0] ic, dc, ecmd;
        logic [3:0] resp, rtag, eitag, edtag;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ic = $urandom_range(0, 3) == 0 ? BUS_NONE : BUS_LOAD;
            dc = 2'($urandom_range(0, 2));
            t = $urandom_range(1, 15);
            resp = ($urandom_range(0, 3) != 0 && m_owner[t] == 0) ? 4'(t) : 4'd0;
            t = $urandom_range(1, 15);
            rtag = ($urandom_range(0, 1) == 1 && m_owner[t] != 0) ? 4'(t) : 4'd0;
            drive(ic, dc, resp, rtag);
            w = model_win();
            ecmd = w < 0 ? BUS_NONE : (w == 0 ? imem_cmd : dmem_cmd);
            eitag = m_owner[rtag] == 1 ? rtag : 4'd0;
            edtag = m_owner[rtag] == 2 ? rtag : 4'd0;
            checks++; if (p_cmd !== ecmd || p_addr !== (w < 0 ? 64'd0 : (w == 0 ? imem_addr : dmem_addr))) begin errors++; $display("FAIL rnd_port%0d: got %0h/%0h expected cmd %0h winner %0d", n, p_cmd, p_addr, ecmd, w); end
            checks++; if (p_data !== dmem_wdata) begin errors++; $display("FAIL rnd_wdata%0d: got %0h expected %0h", n, p_data, dmem_wdata); end
            checks++; if (imem_response !== (w == 0 ? resp : 4'd0) || dmem_response !== (w == 1 ? resp : 4'd0)) begin errors++; $display("FAIL rnd_resp%0d: got %0h/%0h expected winner %0d resp %0h", n, imem_response, dmem_response, w, resp); end
            checks++; if (imem_tag !== eitag || dmem_tag !== edtag) begin errors++; $display("FAIL rnd_tag%0d: got %0h/%0h expected %0h/%0h", n, imem_tag, dmem_tag, eitag, edtag); end
            checks++; if (imem_data !== mem_data || dmem_data !== mem_data) begin errors++; $display("FAIL rnd_rdata%0d: got %0h/%0h expected %0h", n, imem_data, dmem_data, mem_data); end
            checks++; if (imem_outst !== 4'(m_icnt) || dmem_outst !== 4'(m_dcnt)) begin errors++; $display("FAIL rnd_outst%0d: got %0d/%0d expected %0d/%0d", n, imem_outst, dmem_outst, m_icnt, m_dcnt); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err%0d: got %0b expected %0b", n, err, m_err); end
            tick();
        end
        drive(BUS_NONE, BUS_NONE, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_imem_loads();
        test_burst();
        test_reject();
        test_limit();
        test_same_cycle();
        test_unknown_tag();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
